qpsk_preamble_detector: RTL and testbench

- Downstream consumer of the QPSK I/Q symbol generator; takes the rectangular-pulse I/Q sample stream (SAMPLES_PER_BIT samples per symbol).
- Makes per-sample hard decisions and runs a symbol-spaced FIR-style correlator against a fixed preamble pattern.
- On detection, an FSM slices the following payload symbols at mid-symbol and emits them with a valid strobe, then re-arms.

---
 rtl/qpsk_det_pkg.sv | 18 +
 rtl/qpsk_preamble_detector_if.sv | 33 +++
 rtl/qpsk_tap_correlator.sv | 69 ++++++
 rtl/qpsk_preamble_detector.sv | 109 ++++++++++
 tb/tb_qpsk_preamble_detector.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/qpsk_det_pkg.sv
// Shared types and constants for the QPSK preamble detector.
package qpsk_det_pkg;

    // Detector FSM: hunting for the preamble, or slicing payload symbols.
    typedef enum logic [0:0] {
        SEARCH  = 1'b0,
        PAYLOAD = 1'b1
    } state_t;

    // Symbol k sits at bits [2k+1:2k]; bit1 = I, bit0 = Q.
    localparam logic [31:0] DEFAULT_PREAMBLE = 32'hE41B_E41B;

    // Width needed to hold a bit-match score in 0..2*pl.
    function automatic int score_w(input int pl);
        return $clog2(2 * pl + 1);
    endfunction

endpackage

// File: rtl/qpsk_preamble_detector_if.sv
// Sample-in / detection-out bundle of the QPSK preamble detector.
// Handshake: in_valid qualifies i_in/q_in for one cycle and there is no
// backpressure, so every cycle with in_valid high consumes one sample.
// preamble_det, sym_valid and frame_done are single-cycle strobes.
interface qpsk_preamble_detector_if
    import qpsk_det_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int SCORE_W = score_w(16)
);
    logic                     in_valid;
    logic signed [DATA_W-1:0] i_in;
    logic signed [DATA_W-1:0] q_in;
    logic                     preamble_det;
    logic [SCORE_W-1:0]       score;
    logic [1:0]               sym_out;
    logic                     sym_valid;
    logic                     frame_done;
    logic                     busy;
    state_t                   fsm_state;

    // Sample source side.
    modport master (
        output in_valid, i_in, q_in,
        input  preamble_det, score, sym_out, sym_valid, frame_done, busy, fsm_state
    );

    // Detector side.
    modport slave (
        input  in_valid, i_in, q_in,
        output preamble_det, score, sym_out, sym_valid, frame_done, busy, fsm_state
    );
endinterface

// File: rtl/qpsk_tap_correlator.sv
// Hard decisions, decision history and symbol-spaced preamble correlator.
// Only ages up to the oldest tap are kept: older decisions never reach a
// tap, so a longer history would be indistinguishable from this one.
module qpsk_tap_correlator
    import qpsk_det_pkg::*;
#(
    parameter int                        DATA_W           = 16,
    parameter int                        SAMPLES_PER_BIT  = 16,
    parameter int                        PREAMBLE_LEN     = 16,
    parameter logic [2*PREAMBLE_LEN-1:0] PREAMBLE_PATTERN = DEFAULT_PREAMBLE,
    parameter int                        THRESHOLD        = 30,
    localparam int                       SCORE_W          = score_w(PREAMBLE_LEN)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] i_in,
    input  logic signed [DATA_W-1:0] q_in,
    output logic [1:0]               dec,
    output logic                     hit,
    output logic [SCORE_W-1:0]       score
);
    localparam int DEPTH  = PREAMBLE_LEN * SAMPLES_PER_BIT;
    localparam int SPAN   = (PREAMBLE_LEN - 1) * SAMPLES_PER_BIT;
    localparam int FILL_W = $clog2(DEPTH + 1);
    localparam logic signed [DATA_W-1:0] ZERO = '0;

    logic [2*SPAN-1:0]  hist;
    logic [2*SPAN+1:0]  hist_next;
    logic [SCORE_W-1:0] score_next;
    logic [FILL_W-1:0]  fill_cnt;
    logic               fill_ok;
    logic [1:0]         tap;
    logic [1:0]         match;

    // Zero counts as positive on both rails.
    assign dec       = {(i_in >= ZERO), (q_in >= ZERO)};
    assign hist_next = {hist, dec};
    // Counting the current sample, the window has seen a full preamble span.
    assign fill_ok   = (fill_cnt >= FILL_W'(DEPTH - 1));
    assign hit       = in_valid && fill_ok && (score_next >= SCORE_W'(THRESHOLD));

    // XNOR + popcount of the window that includes the incoming sample.
    always_comb begin
        score_next = '0;
        tap        = '0;
        match      = '0;
        for (int k = 0; k < PREAMBLE_LEN; k++) begin
            tap        = hist_next[2*(PREAMBLE_LEN-1-k)*SAMPLES_PER_BIT +: 2];
            match      = ~(tap ^ PREAMBLE_PATTERN[2*k +: 2]);
            score_next = score_next + SCORE_W'(match[1]) + SCORE_W'(match[0]);
        end
    end

    // History shift, saturating fill count and registered score, all frozen in gaps.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist     <= '0;
            fill_cnt <= '0;
            score    <= '0;
        end else if (in_valid) begin
            hist  <= hist_next[2*SPAN-1:0];
            score <= score_next;
            if (fill_cnt != FILL_W'(DEPTH)) begin
                fill_cnt <= fill_cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/qpsk_preamble_detector.sv
// QPSK preamble detector: correlates the hard-decision stream against a fixed
// preamble, then slices PAYLOAD_SYMS symbols at mid-symbol and re-arms.
module qpsk_preamble_detector
    import qpsk_det_pkg::*;
#(
    parameter int                        DATA_W           = 16,
    parameter int                        SAMPLES_PER_BIT  = 16,
    parameter int                        PREAMBLE_LEN     = 16,
    parameter logic [2*PREAMBLE_LEN-1:0] PREAMBLE_PATTERN = DEFAULT_PREAMBLE,
    parameter int                        THRESHOLD        = 30,
    parameter int                        PAYLOAD_SYMS     = 6
) (
    input logic                    clk,
    input logic                    rst,
    qpsk_preamble_detector_if.slave bus
);
    localparam int SPB     = SAMPLES_PER_BIT;
    localparam int SCORE_W = score_w(PREAMBLE_LEN);
    localparam int SC_MAX  = SPB * PAYLOAD_SYMS + SPB / 2;
    localparam int SC_W    = $clog2(SC_MAX + 1);
    localparam int PC_W    = $clog2(PAYLOAD_SYMS + 1);

    state_t             state;
    logic [SC_W-1:0]    sc;
    logic [SC_W-1:0]    sc_inc;
    logic [SC_W-1:0]    cap_point;
    logic [PC_W-1:0]    pc;
    logic [1:0]         dec;
    logic               hit;
    logic [SCORE_W-1:0] score;
    logic               det_q;
    logic [1:0]         sym_q;
    logic               sym_valid_q;
    logic               frame_done_q;

    qpsk_tap_correlator #(
        .DATA_W           (DATA_W),
        .SAMPLES_PER_BIT  (SAMPLES_PER_BIT),
        .PREAMBLE_LEN     (PREAMBLE_LEN),
        .PREAMBLE_PATTERN (PREAMBLE_PATTERN),
        .THRESHOLD        (THRESHOLD)
    ) u_corr (
        .clk      (clk),
        .rst      (rst),
        .in_valid (bus.in_valid),
        .i_in     (bus.i_in),
        .q_in     (bus.q_in),
        .dec      (dec),
        .hit      (hit),
        .score    (score)
    );

    // Mid-symbol sample of payload symbol pc, counted from the detection sample.
    always_comb begin
        sc_inc    = sc + 1'b1;
        cap_point = SC_W'(SPB * (int'(pc) + 1) + SPB / 2);
    end

    // Detection / payload FSM with registered strobes; everything freezes in gaps.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= SEARCH;
            sc           <= '0;
            pc           <= '0;
            det_q        <= 1'b0;
            sym_q        <= 2'b00;
            sym_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            det_q        <= 1'b0;
            sym_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            if (bus.in_valid) begin
                case (state)
                    SEARCH: begin
                        if (hit) begin
                            det_q <= 1'b1;
                            state <= PAYLOAD;
                            sc    <= '0;
                            pc    <= '0;
                        end
                    end
                    PAYLOAD: begin
                        // Correlator hits are ignored until the frame completes.
                        sc <= sc_inc;
                        if (sc_inc == cap_point) begin
                            sym_q       <= dec;
                            sym_valid_q <= 1'b1;
                            pc          <= pc + 1'b1;
                            if (pc == PC_W'(PAYLOAD_SYMS - 1)) begin
                                frame_done_q <= 1'b1;
                                state        <= SEARCH;
                            end
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end

    assign bus.preamble_det = det_q;
    assign bus.score        = score;
    assign bus.sym_out      = sym_q;
    assign bus.sym_valid    = sym_valid_q;
    assign bus.frame_done   = frame_done_q;
    assign bus.busy         = (state == PAYLOAD);
    assign bus.fsm_state    = state;
endmodule

// File: tb/tb_qpsk_preamble_detector.sv
// Bench for qpsk_preamble_detector: random I/Q stimulus against a
// sample-history reference model, plus frame-level timing checks.
module tb_qpsk_preamble_detector;
    import qpsk_det_pkg::*;

    localparam int          PL    = 16;
    localparam int          SPB   = 16;
    localparam int          THR   = 30;
    localparam int          PS    = 6;
    localparam int          DEPTH = PL * SPB;
    localparam logic [31:0] PAT   = 32'hE41B_E41B;

    logic clk = 1'b0;
    logic rst = 1'b1;

    qpsk_preamble_detector_if bus_if ();

    qpsk_preamble_detector dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- counters and logs ----------------
    int checks   = 0;
    int failures = 0;
    int sample_no = 0;
    int det_idx[$];
    int sym_idx[$];
    int fd_idx[$];
    logic [1:0] sym_val[$];
    logic busy_any;
    int watch_idx = -1;
    int watch_score;

    // ---------------- reference model ----------------
    logic [1:0] hist_q[$];
    logic [1:0] exp_q[$];
    bit   m_payload;
    int   t0;
    int   m_pc;
    logic [1:0] m_sym;
    int   exp_score;
    bit   exp_det, exp_sv, exp_fd;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist_q.delete();
        exp_q.delete();
        m_payload = 0;
        m_pc      = 0;
        m_sym     = 2'b00;
        exp_score = 0;
        exp_det   = 0;
        exp_sv    = 0;
        exp_fd    = 0;
    endtask

    // One accepted (or idle) cycle of the specified behaviour.
    task automatic model_sample(input logic v, input logic signed [15:0] iv, input logic signed [15:0] qv);
        logic [1:0]  d, h, p;
        logic [31:0] pat;
        int n, s, idx;
        exp_det = 0;
        exp_sv  = 0;
        exp_fd  = 0;
        if (!v) return;
        d = {iv >= 0, qv >= 0};
        hist_q.push_back(d);
        n   = hist_q.size();
        pat = PAT;
        s   = 0;
        for (int k = 0; k < PL; k++) begin
            idx = n - 1 - (PL - 1 - k) * SPB;
            h   = (idx >= 0) ? hist_q[idx] : 2'b00;
            p   = pat[2*k +: 2];
            s  += (h[1] == p[1]) + (h[0] == p[0]);
        end
        exp_score = s;
        if (!m_payload) begin
            if (n >= DEPTH && s >= THR) begin
                exp_det   = 1;
                m_payload = 1;
                t0        = n - 1;
                m_pc      = 0;
            end
        end else if ((n - 1 - t0) == SPB * (m_pc + 1) + SPB / 2) begin
            exp_sv = 1;
            m_sym  = d;
            exp_q.push_back(d);
            if (m_pc == PS - 1) begin
                exp_fd    = 1;
                m_payload = 0;
            end
            m_pc++;
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic compare_outputs();
        logic [1:0] want;
        check("det",   bus_if.preamble_det, exp_det);
        check("score", bus_if.score,        exp_score);
        check("sv",    bus_if.sym_valid,    exp_sv);
        check("fd",    bus_if.frame_done,   exp_fd);
        check("busy",  bus_if.busy,         m_payload);
        check("sym_hold", bus_if.sym_out,   m_sym);
        if (bus_if.sym_valid === 1'b1) begin
            check("sym_q_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                want = exp_q.pop_front();
                check("sym_val", bus_if.sym_out, want);
            end
        end
    endtask

    task automatic log_events(input logic v);
        int idx;
        idx = sample_no - 1;
        if (bus_if.busy === 1'b1) busy_any = 1'b1;
        if (v && idx == watch_idx) watch_score = bus_if.score;
        if (bus_if.preamble_det === 1'b1) det_idx.push_back(idx);
        if (bus_if.sym_valid === 1'b1) begin
            sym_idx.push_back(idx);
            sym_val.push_back(bus_if.sym_out);
        end
        if (bus_if.frame_done === 1'b1) fd_idx.push_back(idx);
    endtask

    task automatic clear_logs();
        det_idx.delete();
        sym_idx.delete();
        sym_val.delete();
        fd_idx.delete();
        busy_any = 1'b0;
    endtask

    function automatic int det_at(input int i);
        return (i < det_idx.size()) ? det_idx[i] : -1;
    endfunction

    function automatic int sym_at(input int i);
        return (i < sym_idx.size()) ? sym_idx[i] : -1;
    endfunction

    function automatic int symv_at(input int i);
        return (i < sym_val.size()) ? int'(sym_val[i]) : -1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step(input logic v, input logic signed [15:0] iv, input logic signed [15:0] qv);
        bus_if.in_valid = v;
        bus_if.i_in     = iv;
        bus_if.q_in     = qv;
        @(posedge clk);
        #1;
        if (v) sample_no++;
        model_sample(v, iv, qv);
        compare_outputs();
        log_events(v);
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        bus_if.in_valid = 1'($urandom_range(0, 1));
        bus_if.i_in     = 16'($urandom());
        bus_if.q_in     = 16'($urandom());
        @(posedge clk);
        #1;
        model_reset();
        check("rst_det",   bus_if.preamble_det, 0);
        check("rst_score", bus_if.score,        0);
        check("rst_sym",   bus_if.sym_out,      0);
        check("rst_sv",    bus_if.sym_valid,    0);
        check("rst_fd",    bus_if.frame_done,   0);
        check("rst_busy",  bus_if.busy,         0);
        rst = 1'b0;
    endtask

    function automatic logic signed [15:0] level(input logic b, input bit rnd);
        logic signed [15:0] v;
        if (!rnd) return b ? 16'sd16384 : -16'sd16384;
        v = 16'($urandom_range(0, 32767));
        return b ? v : (-v - 16'sd1);
    endfunction

    task automatic send_noise(input int n);
        for (int j = 0; j < n; j++) step(1'b1, 16'($urandom()), 16'($urandom()));
    endtask

    // Preamble (optionally corrupted) followed by six payload symbols.
    task automatic send_frame(input logic [11:0] pay, input bit gap, input bit rnd,
                              input int inv_a, input int inv_b, input int flip_sym,
                              input int stop_after);
        logic [31:0] pat;
        logic [1:0]  b;
        int cnt;
        pat = PAT;
        cnt = 0;
        for (int s = 0; s < PL + PS; s++) begin
            if (s < PL) begin
                b = pat[2*s +: 2];
                if (s == inv_a || s == inv_b) b = ~b;
                if (s == flip_sym) b[1] = ~b[1];
            end else begin
                b = pay[11 - 2*(s - PL) -: 2];
            end
            for (int t = 0; t < SPB; t++) begin
                if (stop_after >= 0 && cnt >= stop_after) return;
                if (gap) step(1'b0, 16'($urandom()), 16'($urandom()));
                step(1'b1, level(b[1], rnd), level(b[0], rnd));
                cnt++;
            end
        end
    endtask

    // ---------------- test sequence ----------------
    localparam logic [11:0] PAY = {2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b00};

    task automatic check_frame(input string tag, input int base, input logic [11:0] pay);
        logic [1:0] w;
        check({tag, "_det_cnt"}, det_idx.size(), 1);
        check({tag, "_det_idx"}, det_at(0) - base, 240);
        check({tag, "_sym_cnt"}, sym_idx.size(), PS);
        for (int j = 0; j < PS; j++) begin
            w = pay[11 - 2*j -: 2];
            check({tag, "_sym_idx"}, sym_at(j) - base, 264 + 16 * j);
            check({tag, "_sym_val"}, symv_at(j), w);
        end
        check({tag, "_fd_cnt"}, fd_idx.size(), 1);
        check({tag, "_fd_idx"}, (fd_idx.size() > 0) ? fd_idx[0] - base : -1, 344);
    endtask

    initial begin
        int base;
        logic [11:0] pay2;
        bus_if.in_valid = 1'b0;
        bus_if.i_in     = '0;
        bus_if.q_in     = '0;
        clear_logs();
        do_reset();

        // Fill guard: preamble starts right after reset.
        base = sample_no;
        send_frame(PAY, 0, 0, -1, -1, -1, -1);
        send_noise(120);
        check("fill_first_det", det_at(0) - base, 255);

        // Ideal frame after a filled history.
        do_reset();
        send_noise(300);
        clear_logs();
        base = sample_no;
        send_frame(PAY, 0, 0, -1, -1, -1, -1);
        check_frame("ideal", base, PAY);
        check("ideal_busy_end", bus_if.busy, 0);

        // Two symbols inverted: score 28, no detection.
        send_noise(50);
        clear_logs();
        base = sample_no;
        watch_idx = base + 240;
        send_frame(PAY, 0, 1, 3, 9, -1, -1);
        check("inv_score", watch_score, 28);
        check("inv_det_cnt", det_idx.size(), 0);
        check("inv_busy", busy_any, 0);

        // One bit flipped: score 31, detection.
        clear_logs();
        base = sample_no;
        watch_idx = base + 240;
        send_frame(PAY, 0, 1, -1, -1, 5, -1);
        check("flip_score", watch_score, 31);
        check_frame("flip", base, PAY);

        // Every other cycle idle.
        send_noise(40);
        clear_logs();
        base = sample_no;
        send_frame(PAY, 1, 1, -1, -1, -1, -1);
        check_frame("gap", base, PAY);

        // Reset after the third payload symbol.
        send_noise(40);
        clear_logs();
        base = sample_no;
        send_frame(PAY, 0, 0, -1, -1, -1, 300);
        check("mid_sym_cnt", sym_idx.size(), 3);
        do_reset();
        check("mid_fd_cnt", fd_idx.size(), 0);
        send_noise(300);
        clear_logs();
        base = sample_no;
        send_frame(PAY, 0, 1, -1, -1, -1, -1);
        check_frame("post_rst", base, PAY);

        // Back-to-back frames.
        send_noise(20);
        clear_logs();
        base = sample_no;
        pay2 = 12'($urandom());
        send_frame(PAY, 0, 1, -1, -1, -1, -1);
        send_frame(pay2, 0, 1, -1, -1, -1, -1);
        check("b2b_det_cnt", det_idx.size(), 2);
        check("b2b_det0", det_at(0) - base, 240);
        check("b2b_det_gap", det_at(1) - det_at(0), 352);
        check("b2b_sym_cnt", sym_idx.size(), 2 * PS);
        check("b2b_fd_cnt", fd_idx.size(), 2);
        check("b2b_last_sym", symv_at(11), pay2[1:0]);

        for (int j = 0; j < 10; j++) step(1'b0, 16'($urandom()), 16'($urandom()));
        check("exp_q_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
